// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI frame arbiter: byte width, FSM state
// encoding and the index-width helper used for requester IDs and counters.
package spi_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_frame_arbiter_rr_arbiter.sv
// Round-robin picker: the first requesting bit at or after ptr, wrapping
// modulo N_REQ. Purely combinational; the pointer register lives in the parent.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [idx_width(N_REQ)-1:0] ptr,
  input  logic                        en,
  output logic [N_REQ-1:0]            grant,
  output logic [idx_width(N_REQ)-1:0] grant_idx,
  output logic                        grant_any
);

  localparam int ID_W = idx_width(N_REQ);

  int cand;

  // Scan from the pointer position and stop at the first active request
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (en && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Shares one SPI interface among N_REQ requesters. One frame in flight at a
// time: serialise the granted frame into the master FIFO, wait for the same
// number of reply bytes, read them out and hand them back to the requester.
// A reply timeout and a drain state keep stale or missing replies from
// wedging the shared bus.
module spi_frame_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int BYTES_PER_FRAME = 2,
  parameter int TIMEOUT         = 1023
) (
  input  logic                                      sys_clk,
  input  logic                                      n_rst,
  input  logic [N_REQ-1:0]                          req_valid,
  input  logic [N_REQ*BYTE_W*BYTES_PER_FRAME-1:0]   req_data,
  output logic [N_REQ-1:0]                          req_ready,
  output logic [N_REQ-1:0]                          rsp_valid,
  output logic [BYTE_W*BYTES_PER_FRAME-1:0]         rsp_data,
  output logic                                      rsp_timeout,
  output logic [BYTE_W-1:0]                         spi_in_data,
  output logic                                      spi_in_ena,
  output logic                                      spi_rdreq,
  input  logic [BYTE_W-1:0]                         spi_out_data,
  input  logic                                      spi_have_msg,
  input  logic [7:0]                                spi_len,
  output logic                                      busy,
  output logic [idx_width(N_REQ)-1:0]               grant_id
);

  localparam int FRAME_W = BYTE_W * BYTES_PER_FRAME;
  localparam int ID_W    = idx_width(N_REQ);
  localparam int CNT_W   = idx_width(BYTES_PER_FRAME);
  localparam int TO_W    = idx_width(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      grant_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [CNT_W-1:0]     byte_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [FRAME_W-1:0]   rx_shift_q;
  logic [FRAME_W-1:0]   rsp_data_q;
  logic                 abort_q;
  logic                 empty_seen_q;

  logic                 arb_en;
  logic [N_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [FRAME_W-1:0]   frame_sel;
  logic [FRAME_W-1:0]   rx_next;
  logic [N_REQ-1:0]     grant_onehot;

  // Arbitration is only meaningful in IDLE with no stale reply bytes waiting
  assign arb_en = (state_q == ST_IDLE) && !spi_have_msg;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // First received byte ends up in the MSB after BYTES_PER_FRAME shifts
  assign rx_next      = FRAME_W'({rx_shift_q, spi_out_data});
  assign grant_onehot = N_REQ'(1) << grant_q;
  assign rsp_data     = rsp_data_q;
  assign grant_id     = grant_q;

  // Select the winner's frame slice through the one-hot grant
  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        frame_sel = frame_sel | req_data[i*FRAME_W +: FRAME_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and interface strobes
  always_comb begin
    state_d     = state_q;
    spi_in_ena  = 1'b0;
    spi_in_data = '0;
    spi_rdreq   = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_timeout = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (spi_have_msg) begin
          state_d = ST_FLUSH;
        end else if (arb_any) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        spi_in_ena  = 1'b1;
        spi_in_data = frame_q[int'(byte_cnt_q)*BYTE_W +: BYTE_W];
        if (byte_cnt_q == LAST_BYTE) begin
          req_ready = grant_onehot;
        end
        if (byte_cnt_q == '0) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A complete reply beats the timeout when both land together
        if (spi_len >= 8'(BYTES_PER_FRAME)) begin
          state_d = ST_READ;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_FLUSH;
        end
      end
      ST_READ: begin
        spi_rdreq = 1'b1;
        if (byte_cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_FLUSH: begin
        spi_rdreq = spi_have_msg;
        // Two empty cycles in a row cover the FIFO's empty-flag latency
        if (!spi_have_msg && empty_seen_q) begin
          state_d = abort_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        rsp_valid   = grant_onehot;
        rsp_timeout = abort_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping, byte/timeout counters and reply capture
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q        <= '0;
      grant_q      <= '0;
      frame_q      <= '0;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      rx_shift_q   <= '0;
      rsp_data_q   <= '0;
      abort_q      <= 1'b0;
      empty_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_SEND) begin
            grant_q    <= arb_idx;
            ptr_q      <= (arb_idx == LAST_ID) ? '0 : arb_idx + ID_W'(1);
            frame_q    <= frame_sel;
            byte_cnt_q <= LAST_BYTE;
            abort_q    <= 1'b0;
          end else if (state_d == ST_FLUSH) begin
            abort_q      <= 1'b0;
            empty_seen_q <= 1'b0;
          end
        end
        ST_SEND: begin
          if (byte_cnt_q == '0) begin
            to_cnt_q <= '0;
          end else begin
            byte_cnt_q <= byte_cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (state_d == ST_READ) begin
            byte_cnt_q <= LAST_BYTE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_d == ST_FLUSH) begin
              abort_q      <= 1'b1;
              empty_seen_q <= 1'b0;
            end
          end
        end
        ST_READ: begin
          rx_shift_q <= rx_next;
          if (byte_cnt_q == '0) begin
            rsp_data_q <= rx_next;
          end else begin
            byte_cnt_q <= byte_cnt_q - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          empty_seen_q <= !spi_have_msg;
          if (state_d == ST_DONE) begin
            rsp_data_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: a behavioural SPI slave (byte queue) answers
// each frame, and a transaction-level model predicts the round-robin winner,
// the bytes written, the reply contents, the timeout flag and the turnaround.
module tb_spi_frame_arbiter;

  localparam int N_REQ = 4;
  localparam int BPF   = 2;
  localparam int TMO   = 15;
  localparam int FW    = 8 * BPF;

  logic                   sys_clk = 1'b0;
  logic                   n_rst   = 1'b1;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*FW-1:0]    req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [FW-1:0]          rsp_data;
  logic                   rsp_timeout;
  logic [7:0]             spi_in_data;
  logic                   spi_in_ena;
  logic                   spi_rdreq;
  logic [7:0]             spi_out_data;
  logic                   spi_have_msg;
  logic [7:0]             spi_len;
  logic                   busy;
  logic [1:0]             grant_id;

  always #5 sys_clk = ~sys_clk;

  spi_frame_arbiter #(
    .N_REQ           (N_REQ),
    .BYTES_PER_FRAME (BPF),
    .TIMEOUT         (TMO)
  ) dut (
    .sys_clk      (sys_clk),
    .n_rst        (n_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .spi_in_data  (spi_in_data),
    .spi_in_ena   (spi_in_ena),
    .spi_rdreq    (spi_rdreq),
    .spi_out_data (spi_out_data),
    .spi_have_msg (spi_have_msg),
    .spi_len      (spi_len),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  int           n_cmp = 0;
  int           n_mis = 0;
  int           cyc   = 0;

  logic [7:0]   sq[$];
  logic [7:0]   sent[$];
  logic [7:0]   reply_bytes[$];
  logic         pop_pend;
  bit           reply_armed;
  int           reply_cd;
  int           cur_delay;

  int           mdl_ptr;
  bit           txn_open;
  int           owner;
  logic [FW-1:0] exp_frame;
  logic [FW-1:0] exp_rsp;
  bit           exp_to;
  int           exp_lat;
  int           t_grant;

  int           force_mode;
  int           force_delay;
  bit           force_reply_en;
  logic [FW-1:0] force_reply;
  bit           hold_all;
  bit           rand_req;

  int           n_rsp;
  int           grant_log[$];
  logic [FW-1:0] last_rsp_data;
  logic         last_rsp_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Round-robin reference: first requester at or after the pointer
  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic drive_slave();
    spi_len      = 8'(sq.size());
    spi_have_msg = (sq.size() != 0);
    spi_out_data = (sq.size() != 0) ? sq[0] : 8'h00;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 0);
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 0);
    chk({tag, "_in_data"}, 64'(spi_in_data), 0);
    chk({tag, "_in_ena"}, 64'(spi_in_ena), 0);
    chk({tag, "_rdreq"}, 64'(spi_rdreq), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_grant_id"}, 64'(grant_id), 0);
  endtask

  // One clock: observe at the falling edge, update the slave after the rise
  task automatic step();
    int               w;
    int               m;
    int               d;
    int               r;
    logic [7:0]       b;
    logic [FW-1:0]    v;
    logic [N_REQ-1:0] e;
    @(negedge sys_clk);
    cyc++;
    if (req_ready != '0) begin
      w = rr_pick(req_valid, mdl_ptr);
      e = '0;
      if (w >= 0) e[w] = 1'b1;
      chk("grant_onehot", 64'(req_ready), 64'(e));
      chk("grant_id", 64'(grant_id), 64'(w));
      chk("stale_drained", 64'(sq.size()), 0);
      chk("grant_while_open", 64'(txn_open), 0);
      if (w < 0) w = 0;
      mdl_ptr   = (w + 1) % N_REQ;
      owner     = w;
      exp_frame = req_data[w*FW +: FW];
      sent.delete();
      txn_open  = 1'b1;
      t_grant   = cyc;
      grant_log.push_back(w);
      if (force_mode >= 0) m = force_mode;
      else begin
        r = int'($urandom_range(0, 9));
        m = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      end
      d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, TMO - 1));
      reply_bytes.delete();
      exp_rsp = '0;
      if (m != 2) begin
        for (int k = 0; k < BPF + ((m == 1) ? 1 : 0); k++) begin
          b = 8'($urandom);
          if (force_reply_en && k < BPF) b = force_reply[(BPF-1-k)*8 +: 8];
          reply_bytes.push_back(b);
          if (k < BPF) exp_rsp = FW'({exp_rsp, b});
        end
      end
      exp_to    = (m == 2);
      exp_lat   = (m == 2) ? (BPF + TMO + 2) : (2 * BPF + d + 1);
      cur_delay = d;
      if (hold_all) req_data[w*FW +: FW] = FW'($urandom);
      else          req_valid[w] = 1'b0;
    end
    if (spi_in_ena) begin
      sent.push_back(spi_in_data);
      if (sent.size() == BPF) begin
        v = '0;
        foreach (sent[k]) v = FW'({v, sent[k]});
        chk("frame_out", 64'(v), 64'(exp_frame));
        if (reply_bytes.size() != 0) begin
          reply_armed = 1'b1;
          reply_cd    = cur_delay;
        end
      end else if (sent.size() > BPF) begin
        chk("write_count", 64'(sent.size()), BPF);
      end
    end
    pop_pend = spi_rdreq;
    if (spi_rdreq) chk("rd_has_data", 64'(spi_have_msg), 1);
    if (rsp_valid != '0) begin
      if (!txn_open) begin
        chk("rsp_unexpected", 64'(rsp_valid), 0);
      end else begin
        e = '0;
        e[owner] = 1'b1;
        chk("rsp_owner", 64'(rsp_valid), 64'(e));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        chk("rsp_data", 64'(rsp_data), exp_to ? 64'(0) : 64'(exp_rsp));
        chk("turnaround", 64'(cyc - t_grant), 64'(exp_lat));
        txn_open      = 1'b0;
        last_rsp_data = rsp_data;
        last_rsp_to   = rsp_timeout;
        n_rsp++;
      end
    end
    if (rand_req) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_data[i*FW +: FW] = FW'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    @(posedge sys_clk);
    #1;
    if (pop_pend && sq.size() != 0) void'(sq.pop_front());
    if (reply_armed) begin
      if (reply_cd == 0) begin
        foreach (reply_bytes[k]) sq.push_back(reply_bytes[k]);
        reply_armed = 1'b0;
      end else begin
        reply_cd--;
      end
    end
    drive_slave();
  endtask

  task automatic wait_rsp(input int max_cyc, input string tag);
    int start;
    start = n_rsp;
    for (int k = 0; k < max_cyc && n_rsp == start; k++) step();
    chk(tag, 64'(n_rsp - start), 1);
  endtask

  initial begin
    int   start;
    bit   seen_read;
    req_valid      = '0;
    req_data       = '0;
    force_mode     = 0;
    force_delay    = -1;
    force_reply_en = 1'b0;
    force_reply    = '0;
    hold_all       = 1'b0;
    rand_req       = 1'b0;
    reply_armed    = 1'b0;
    txn_open       = 1'b0;
    mdl_ptr        = 0;
    n_rsp          = 0;
    pop_pend       = 1'b0;
    drive_slave();
    #2 n_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_zero("reset");
    @(negedge sys_clk);
    n_rst = 1'b1;

    // Fairness: all four requesting continuously
    for (int i = 0; i < N_REQ; i++) req_data[i*FW +: FW] = FW'($urandom);
    hold_all  = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) wait_rsp(100, "fair_rsp");
    req_valid = '0;
    hold_all  = 1'b0;
    for (int k = 0; k < 5; k++) chk("fair_order", 64'(grant_log[k]), 64'(k % N_REQ));

    // Single request with a known frame and reply
    req_data[0 +: FW] = 16'hA55A;
    req_valid      = 4'b0001;
    force_delay    = 10;
    force_reply_en = 1'b1;
    force_reply    = 16'h1234;
    wait_rsp(100, "single_rsp");
    chk("single_data", 64'(last_rsp_data), 64'h1234);
    chk("single_to", 64'(last_rsp_to), 0);
    chk("single_grant", 64'(grant_log[$]), 0);
    force_reply_en = 1'b0;

    // No reply at all: timeout abort
    req_data[2*FW +: FW] = FW'($urandom);
    req_valid  = 4'b0100;
    force_mode = 2;
    wait_rsp(100, "tmo_rsp");
    chk("tmo_flag", 64'(last_rsp_to), 1);
    chk("tmo_data", 64'(last_rsp_data), 0);

    // One byte too many, then a normal frame after the drain
    req_data[3*FW +: FW] = FW'($urandom);
    req_valid   = 4'b1000;
    force_mode  = 1;
    force_delay = -1;
    wait_rsp(100, "extra_rsp");
    chk("extra_to", 64'(last_rsp_to), 0);
    req_data[1*FW +: FW] = FW'($urandom);
    req_valid  = 4'b0010;
    force_mode = 0;
    wait_rsp(100, "after_extra_rsp");
    chk("after_extra_grant", 64'(grant_log[$]), 1);

    // Reply lands on the last WAIT cycle before the timeout
    req_valid   = 4'b0001;
    force_delay = TMO - 1;
    wait_rsp(100, "edge_rsp");
    chk("edge_to", 64'(last_rsp_to), 0);

    // Randomized traffic
    force_mode  = -1;
    force_delay = -1;
    rand_req    = 1'b1;
    start = n_rsp;
    for (int k = 0; k < 40 && n_rsp - start < 30; k++) wait_rsp(200, "rand_rsp");
    rand_req = 1'b0;
    for (int k = 0; k < 2000 && (req_valid != '0 || txn_open); k++) step();
    chk("drain_done", 64'(req_valid) | 64'(txn_open), 0);
    repeat (6) step();

    // Asynchronous reset in the middle of READ
    req_data[2*FW +: FW] = FW'($urandom);
    req_valid   = 4'b0100;
    force_mode  = 0;
    force_delay = 3;
    seen_read   = 1'b0;
    for (int k = 0; k < 100 && !seen_read; k++) begin
      step();
      seen_read = spi_rdreq && txn_open;
    end
    chk("mid_read_reached", 64'(seen_read), 1);
    #2 n_rst = 1'b0;
    #1;
    check_reset_zero("mid_reset");
    txn_open    = 1'b0;
    mdl_ptr     = 0;
    reply_armed = 1'b0;
    sq.delete();
    req_valid   = '0;
    drive_slave();
    @(negedge sys_clk);
    n_rst = 1'b1;
    #1;
    chk("post_rst_busy", 64'(busy), 0);
    req_valid   = '1;
    force_delay = 0;
    wait_rsp(100, "post_rst_rsp");
    chk("post_rst_first", 64'(grant_log[$]), 0);
    req_valid = '0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
